mmap_bus_demux: RTL and testbench
=================================

MMAP_BUS_DEMUX -- requirements
Module: mmap_bus_demux

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4: number of mapped slave ports (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width, a multiple of 8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of granted requests without a response (1..15).
REQ-005 SHALL have parameter MAP, an array of NUM_SLV mmap_rule_t {base, len} entries, default SRAM, ROM, STDOUT, UART regions.
REQ-006 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have master-side inputs m_req_i (1), m_we_i (1), m_be_i (DATA_WIDTH/8), m_addr_i (ADDR_WIDTH) and m_wdata_i (DATA_WIDTH).
REQ-009 SHALL have master-side outputs m_gnt_o (1), m_rvalid_o (1), m_rdata_o (DATA_WIDTH) and m_err_o (1).
REQ-010 SHALL have slave-side outputs s_req_o [NUM_SLV], s_we_o, s_be_o, s_addr_o and s_wdata_o (broadcast).
REQ-011 SHALL have slave-side inputs s_gnt_i [NUM_SLV], s_rvalid_i [NUM_SLV] and s_rdata_i [NUM_SLV][DATA_WIDTH].
REQ-012 SHALL have output proto_err_o, 1: sticky flag set by a stray slave rvalid.

Function
REQ-013 SHALL decode a hit on rule i when m_addr_i >= base and (m_addr_i - base) < len, with both compares unsigned at ADDR_WIDTH (no wrap past the top of the address space).
REQ-014 SHALL select the lowest-index rule on overlapping hits; no hit or len==0 selects the internal error slave (index NUM_SLV).
REQ-015 SHALL assert s_req_o[sel] = m_req_i only when not stalled; all other s_req_o SHALL be 0; when stalled, all s_req_o SHALL be 0.
REQ-016 SHALL stall when outstanding count == MAX_OUTSTANDING, or when count != 0 and sel != cur_q (responses stay in order).
REQ-017 SHALL drive m_gnt_o = s_gnt_i[sel] when not stalled; the error slave grants in the same cycle as m_req_i.
REQ-018 SHALL, on each grant, load cur_q <= sel and add 1 to the count.
REQ-019 SHALL decrement the count on each m_rvalid_o; a grant and a response in the same cycle leave the count unchanged.
REQ-020 SHALL drive m_rvalid_o/m_rdata_o from s_rvalid_i[cur_q]/s_rdata_i[cur_q] combinationally (0 cycles added latency), with m_err_o=0.
REQ-021 SHALL make the error slave respond exactly one cycle after its grant, with m_rvalid_o=1, m_err_o=1 and m_rdata_o=32'hBADC_AB1E zero-extended or truncated to DATA_WIDTH.
REQ-022 SHALL ignore s_rvalid_i[j] when j != cur_q or count == 0, and set proto_err_o, which holds until reset.
REQ-023 SHALL block error-slave requests and forward nothing to any slave port while an error response is pending.

Reset
REQ-024 SHALL clear on rst_ni=0 at a clock edge: count=0, cur_q=0, error-pending=0, proto_err_o=0.
REQ-025 SHALL hold m_gnt_o, m_rvalid_o, m_err_o and s_req_o at 0 throughout reset.
REQ-026 SHALL discard in-flight transactions on mid-operation reset; later responses from those transactions count as stray (REQ-022).

Structure
REQ-027 SHALL place mmap_rule_t {logic [31:0] base, len} and the default rule array in the shared memory-map package, alongside the existing *_BASE/*_LEN constants.
REQ-028 SHALL implement the error slave as sub-module mmap_err_slave (req/gnt/rvalid/err, one register).
REQ-029 SHALL implement the count as a $clog2(MAX_OUTSTANDING+1)-bit register, with an assertion that it never over- or underflows.

Verification
REQ-030 SHALL verify: read 0x0000_0010 (SRAM); slave 0 gnt same cycle, rvalid 2 cycles later with 0x1234_5678 -> m_rdata_o=0x1234_5678, m_err_o=0.
REQ-031 SHALL verify: read 0x1B00_0000 (unmapped) -> gnt same cycle; next cycle m_rvalid_o=1, m_err_o=1, rdata=0xBADC_AB1E; no s_req_o asserted.
REQ-032 SHALL verify: 4 back-to-back SRAM reads with slave responses withheld -> 5th request stalled (m_gnt_o=0) until the first rvalid.
REQ-033 SHALL verify: SRAM read outstanding, then a ROM request at 0x1A00_0000 -> stalled until the SRAM rvalid, then granted the same cycle the count reaches 0.
REQ-034 SHALL verify: addresses 0x1A33_000F and 0x1A33_0010 -> UART hit, then error slave (len boundary).
REQ-035 SHALL verify: reset with 2 outstanding, then slave 0 rvalid -> m_rvalid_o=0, proto_err_o=1.

Source files
------------

// File: rtl/mmap_bus_demux_pkg.sv
// Shared memory map: region constants, rule type and the default rule table
// used by the master-to-slave bus demultiplexer.
package mmap_bus_demux_pkg;

  localparam logic [31:0] SRAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] SRAM_LEN    = 32'h0010_0000;
  localparam logic [31:0] ROM_BASE    = 32'h1A00_0000;
  localparam logic [31:0] ROM_LEN     = 32'h0004_0000;
  localparam logic [31:0] STDOUT_BASE = 32'h1A10_0000;
  localparam logic [31:0] STDOUT_LEN  = 32'h0000_1000;
  localparam logic [31:0] UART_BASE   = 32'h1A33_0000;
  localparam logic [31:0] UART_LEN    = 32'h0000_0010;

  localparam logic [31:0] ERR_RDATA   = 32'hBADC_AB1E;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] len;
  } mmap_rule_t;

  localparam int MMAP_NUM_RULES = 4;

  // Index 0 is the rightmost element, so SRAM is rule 0.
  localparam mmap_rule_t [MMAP_NUM_RULES-1:0] MMAP_DEFAULT = {
    mmap_rule_t'{base: UART_BASE,   len: UART_LEN},
    mmap_rule_t'{base: STDOUT_BASE, len: STDOUT_LEN},
    mmap_rule_t'{base: ROM_BASE,    len: ROM_LEN},
    mmap_rule_t'{base: SRAM_BASE,   len: SRAM_LEN}
  };

endpackage

// File: rtl/mmap_bus_demux_err_slave.sv
// Internal error slave: grants immediately and answers one cycle later.
// Holds at most one response in flight.
module mmap_err_slave (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic gnt_o,
  output logic rvalid_o,
  output logic err_o
);

  logic pend_q, pend_d;

  always_comb begin
    gnt_o  = req_i & ~pend_q;
    pend_d = gnt_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pend_q <= 1'b0;
    else         pend_q <= pend_d;
  end

  assign rvalid_o = pend_q;
  assign err_o    = pend_q;

endmodule

// File: rtl/mmap_bus_demux.sv
// Address-decoding demux from one master to NUM_SLV slaves plus an internal
// error slave; keeps responses in order by stalling on a target change.
module mmap_bus_demux
  import mmap_bus_demux_pkg::*;
#(
  parameter int NUM_SLV         = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter mmap_rule_t [NUM_SLV-1:0] MAP = MMAP_DEFAULT
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               m_req_i,
  input  logic                               m_we_i,
  input  logic [DATA_WIDTH/8-1:0]            m_be_i,
  input  logic [ADDR_WIDTH-1:0]              m_addr_i,
  input  logic [DATA_WIDTH-1:0]              m_wdata_i,
  output logic                               m_gnt_o,
  output logic                               m_rvalid_o,
  output logic [DATA_WIDTH-1:0]              m_rdata_o,
  output logic                               m_err_o,
  output logic [NUM_SLV-1:0]                 s_req_o,
  output logic                               s_we_o,
  output logic [DATA_WIDTH/8-1:0]            s_be_o,
  output logic [ADDR_WIDTH-1:0]              s_addr_o,
  output logic [DATA_WIDTH-1:0]              s_wdata_o,
  input  logic [NUM_SLV-1:0]                 s_gnt_i,
  input  logic [NUM_SLV-1:0]                 s_rvalid_i,
  input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0] s_rdata_i,
  output logic                               proto_err_o
);

  localparam int SEL_W = $clog2(NUM_SLV + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SEL_W-1:0]      ERR_IDX  = SEL_W'(NUM_SLV);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

  logic [NUM_SLV-1:0] hit;
  logic [SEL_W-1:0]   sel, cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               proto_err_q, proto_err_d;
  logic               stall, slv_gnt, fire, rsp;
  logic               err_req, err_gnt, err_rvalid, err_err;

  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_addr_o  = m_addr_i;
  assign s_wdata_o = m_wdata_i;

  // Subtract-then-compare keeps regions ending at the top of the space from wrapping.
  for (genvar g = 0; g < NUM_SLV; g++) begin : g_dec
    assign hit[g] = (m_addr_i >= ADDR_WIDTH'(MAP[g].base)) &&
                    ((m_addr_i - ADDR_WIDTH'(MAP[g].base)) < ADDR_WIDTH'(MAP[g].len));
  end

  always_comb begin
    sel = ERR_IDX;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i);
    end
  end

  always_comb begin
    stall   = (cnt_q == CNT_MAX) || ((cnt_q != '0) && (sel != cur_q)) || err_rvalid;
    s_req_o = '0;
    slv_gnt = 1'b0;
    err_req = 1'b0;
    if (rst_ni && !stall) begin
      if (sel == ERR_IDX) begin
        err_req = m_req_i;
      end else begin
        for (int j = 0; j < NUM_SLV; j++) begin
          if (sel == SEL_W'(j)) begin
            s_req_o[j] = m_req_i;
            slv_gnt    = s_gnt_i[j];
          end
        end
      end
    end
  end

  mmap_err_slave u_err_slave (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (err_req),
    .gnt_o    (err_gnt),
    .rvalid_o (err_rvalid),
    .err_o    (err_err)
  );

  assign m_gnt_o = slv_gnt | err_gnt;

  always_comb begin
    m_rvalid_o  = 1'b0;
    m_rdata_o   = '0;
    m_err_o     = 1'b0;
    proto_err_d = proto_err_q;
    if (cur_q == ERR_IDX && err_rvalid) begin
      m_rvalid_o = 1'b1;
      m_err_o    = err_err;
      m_rdata_o  = ERR_DATA;
    end
    // Only the slave owning the in-flight transactions may answer.
    for (int j = 0; j < NUM_SLV; j++) begin
      if (s_rvalid_i[j]) begin
        if (cnt_q != '0 && cur_q == SEL_W'(j)) begin
          m_rvalid_o = 1'b1;
          m_rdata_o  = s_rdata_i[j];
        end else begin
          proto_err_d = 1'b1;
        end
      end
    end
    if (!rst_ni) begin
      m_rvalid_o = 1'b0;
      m_err_o    = 1'b0;
    end
  end

  always_comb begin
    fire  = m_req_i & m_gnt_o;
    rsp   = m_rvalid_o;
    cnt_d = cnt_q;
    if (fire && !rsp)      cnt_d = cnt_q + CNT_W'(1);
    else if (!fire && rsp) cnt_d = cnt_q - CNT_W'(1);
    cur_d = fire ? sel : cur_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      cur_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err_o = proto_err_q;

  cnt_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fire && !rsp && cnt_q == CNT_MAX));
  cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp && !fire && cnt_q == '0));

endmodule

// File: tb/tb_mmap_bus_demux.sv
// Directed bench for mmap_bus_demux with the default four-region map.
module tb_mmap_bus_demux;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_req, m_we;
  logic [3:0]       m_be;
  logic [31:0]      m_addr, m_wdata;
  logic             m_gnt, m_rvalid, m_err;
  logic [31:0]      m_rdata;
  logic [3:0]       s_req;
  logic             s_we;
  logic [3:0]       s_be;
  logic [31:0]      s_addr, s_wdata;
  logic [3:0]       s_gnt, s_rvalid;
  logic [3:0][31:0] s_rdata;
  logic             proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmap_bus_demux dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .proto_err_o(proto_err)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = 32'h10; m_wdata = '0;
    s_gnt = 4'hF; s_rvalid = 4'h1; s_rdata = '0;
    #1;
    checks++; if (m_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", m_gnt); end
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL rst_sreq: got %b want 0000", s_req); end
    checks++; if (m_rvalid !== 1'b0 || m_err !== 1'b0) begin errors++; $display("FAIL rst_rsp: got rvalid=%b err=%b want 0/0", m_rvalid, m_err); end
    step(); step();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto: got %b want 0", proto_err); end
    m_req = 1'b0; s_rvalid = 4'h0; rst_n = 1'b1;
    step();
  endtask

  task automatic test_sram_read();
    m_req = 1'b1; m_addr = 32'h0000_0010; #1;
    checks++; if (s_req !== 4'b0001 || m_gnt !== 1'b1) begin errors++; $display("FAIL sram_req: got sreq=%b gnt=%b want 0001/1", s_req, m_gnt); end
    checks++; if (s_addr !== 32'h10) begin errors++; $display("FAIL sram_addr: got %h want 00000010", s_addr); end
    step(); m_req = 1'b0; #1;
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL sram_early: got rvalid=%b want 0", m_rvalid); end
    step(); s_rvalid = 4'b0001; s_rdata[0] = 32'h1234_5678; #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h1234_5678 || m_err !== 1'b0) begin
      errors++; $display("FAIL sram_rsp: got rvalid=%b rdata=%h err=%b want 1/12345678/0", m_rvalid, m_rdata, m_err); end
    step(); s_rvalid = 4'b0;
  endtask

  task automatic test_err_slave();
    m_req = 1'b1; m_addr = 32'h1B00_0000; #1;
    checks++; if (m_gnt !== 1'b1 || s_req !== 4'b0) begin errors++; $display("FAIL err_gnt: got gnt=%b sreq=%b want 1/0000", m_gnt, s_req); end
    step(); #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'hBADC_AB1E) begin
      errors++; $display("FAIL err_rsp: got rvalid=%b err=%b rdata=%h want 1/1/badcab1e", m_rvalid, m_err, m_rdata); end
    checks++; if (m_gnt !== 1'b0 || s_req !== 4'b0) begin errors++; $display("FAIL err_block: got gnt=%b sreq=%b want 0/0000", m_gnt, s_req); end
    step();
    checks++; if (m_gnt !== 1'b1 || m_rvalid !== 1'b0) begin errors++; $display("FAIL err_regnt: got gnt=%b rvalid=%b want 1/0", m_gnt, m_rvalid); end
    step(); m_req = 1'b0; #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL err_rsp2: got rvalid=%b err=%b want 1/1", m_rvalid, m_err); end
    step();
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL err_once: got rvalid=%b want 0", m_rvalid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      m_req = 1'b1; m_addr = 32'(4 * i); #1;
      checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d: got %b want 1", i, m_gnt); end
      step();
    end
    m_addr = 32'h40; #1;
    checks++; if (m_gnt !== 1'b0 || s_req !== 4'b0) begin errors++; $display("FAIL b2b_full: got gnt=%b sreq=%b want 0/0000", m_gnt, s_req); end
    step();
    checks++; if (m_gnt !== 1'b0) begin errors++; $display("FAIL b2b_full2: got %b want 0", m_gnt); end
    s_rvalid = 4'b0001; s_rdata[0] = 32'hA0; #1;
    checks++; if (m_rvalid !== 1'b1 || m_gnt !== 1'b0) begin errors++; $display("FAIL b2b_rsp: got rvalid=%b gnt=%b want 1/0", m_rvalid, m_gnt); end
    step(); s_rvalid = 4'b0; #1;
    checks++; if (m_gnt !== 1'b1 || s_req !== 4'b0001) begin errors++; $display("FAIL b2b_5th: got gnt=%b sreq=%b want 1/0001", m_gnt, s_req); end
    step(); m_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 4'b0001; s_rdata[0] = 32'(i + 1); #1;
      checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'(i + 1)) begin errors++; $display("FAIL b2b_drain%0d: got rvalid=%b rdata=%h", i, m_rvalid, m_rdata); end
      step();
    end
    s_rvalid = 4'b0;
  endtask

  task automatic test_order();
    m_req = 1'b1; m_addr = 32'h100; #1;
    checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL ord_sram: got %b want 1", m_gnt); end
    step(); m_addr = 32'h1A00_0000; #1;
    checks++; if (m_gnt !== 1'b0 || s_req !== 4'b0) begin errors++; $display("FAIL ord_stall: got gnt=%b sreq=%b want 0/0000", m_gnt, s_req); end
    step(); s_rvalid = 4'b0001; #1;
    checks++; if (m_rvalid !== 1'b1 || m_gnt !== 1'b0) begin errors++; $display("FAIL ord_rsp: got rvalid=%b gnt=%b want 1/0", m_rvalid, m_gnt); end
    step(); s_rvalid = 4'b0; #1;
    checks++; if (m_gnt !== 1'b1 || s_req !== 4'b0010) begin errors++; $display("FAIL ord_rom: got gnt=%b sreq=%b want 1/0010", m_gnt, s_req); end
    step(); m_req = 1'b0; s_rvalid = 4'b0010; s_rdata[1] = 32'h0000_C0DE; #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h0000_C0DE) begin errors++; $display("FAIL ord_romrsp: got rvalid=%b rdata=%h want 1/0000c0de", m_rvalid, m_rdata); end
    step(); s_rvalid = 4'b0;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ord_proto: got %b want 0", proto_err); end
  endtask

  task automatic test_boundary();
    m_req = 1'b1; m_addr = 32'h1A33_000F; #1;
    checks++; if (s_req !== 4'b1000 || m_gnt !== 1'b1) begin errors++; $display("FAIL bnd_uart: got sreq=%b gnt=%b want 1000/1", s_req, m_gnt); end
    step(); m_req = 1'b0; s_rvalid = 4'b1000; s_rdata[3] = 32'h55; #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h55) begin
      errors++; $display("FAIL bnd_uartrsp: got rvalid=%b err=%b rdata=%h want 1/0/55", m_rvalid, m_err, m_rdata); end
    step(); s_rvalid = 4'b0; m_req = 1'b1; m_addr = 32'h1A33_0010; #1;
    checks++; if (s_req !== 4'b0 || m_gnt !== 1'b1) begin errors++; $display("FAIL bnd_miss: got sreq=%b gnt=%b want 0000/1", s_req, m_gnt); end
    step(); m_req = 1'b0; #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL bnd_errrsp: got rvalid=%b err=%b want 1/1", m_rvalid, m_err); end
    step();
  endtask

  task automatic test_reset_midop();
    m_req = 1'b1; m_addr = 32'h0; step(); step();
    m_req = 1'b0; rst_n = 1'b0; step();
    rst_n = 1'b1; s_rvalid = 4'b0001; #1;
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b want 0", m_rvalid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_proto_pre: got %b want 0", proto_err); end
    step(); s_rvalid = 4'b0; #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mid_proto: got %b want 1", proto_err); end
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mid_sticky: got %b want 1", proto_err); end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_err_slave();
    test_back_to_back();
    test_order();
    test_boundary();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
